icache_fill_responder: RTL
==========================

# icache_fill_responder

Memory-side responder for I$ line-fill traffic: it accepts `memory_request_t` miss requests issued by the multithreaded instruction cache and returns full cache lines, tagged with the requesting thread, after a fixed latency. It models main memory with a line-addressed backing array and a small in-order request queue. One request per thread can be outstanding. It sits between the fetch-stage cache and the top-level memory hierarchy, and is also the bench stand-in for main memory.

## Interface
- `LATENCY`, default `MAIN_MEMORY_LATENCY`: cycles from request acceptance to response; legal range ≥1.
- `NUM_LINES`, default 4096: number of lines in the backing array.
- `LINE_WIDTH`, default `ICACHE_LINE_WIDTH`: line size in bits.
- `QUEUE_DEPTH`, default `THR_PER_CORE`: maximum number of outstanding requests.

- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: request present this cycle.
- `req_info`, in, `memory_request_t`: request fields.
  - `addr` is a line address (byte address >> `ICACHE_RSH_VAL`).
  - The other fields are `is_store`, `data` and `thread_id`.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_data`, out, `LINE_WIDTH`: line read, or store data echoed back.
- `rsp_bus_error`, out, 1: the request's address was out of range; qualified by `rsp_valid`.
- `rsp_thread_id`, out, `THR_PER_CORE_WIDTH`: the thread of the request being answered.
- `overflow_error`, out, 1: sticky flag; a request arrived while the queue was full.

## Operation
- There is no ready/backpressure. Every `req_valid` cycle is a request, and the responder must always accept it.
- Requester contract: at most one pending request per thread. Under this contract the queue never overflows.
- Queue: a circular FIFO of `QUEUE_DEPTH` entries.
  - Each entry holds addr, is_store, data, thread_id and a countdown.
  - Pointers wrap modulo `QUEUE_DEPTH`. The occupancy counter width is clog2(`QUEUE_DEPTH`+1).
- Accept: in a cycle with `req_valid`=1 and the queue not full, the request is pushed with countdown = `LATENCY`-1.
- Overflow: in a cycle with `req_valid`=1 and the queue full, the request is dropped and `overflow_error` is set. It stays set until reset.
- Countdown: every valid entry with a nonzero countdown decrements by 1 each cycle.
- Service: the head entry with countdown 0 is popped, and its response is registered for the next cycle.
  - Read with addr < `NUM_LINES`: `rsp_data` = mem[addr], `rsp_bus_error`=0.
  - Store with addr < `NUM_LINES`: mem[addr] ← data, `rsp_data` = data, `rsp_bus_error`=0.
  - Any request with addr ≥ `NUM_LINES`: `rsp_data`=0, `rsp_bus_error`=1, and the array is unchanged.
- Ordering: service is strictly FIFO. Latency is constant and acceptance is at most one per cycle, so at most one entry reaches 0 per cycle and responses never collide.
- Same-cycle push and pop: both happen, and occupancy is unchanged. A push into a full queue in the same cycle as a pop is still an overflow, because fullness is checked before the pop.
- Read-after-store to the same line: the read returns the stored data, because the store is applied before the read (program order).
- Backing array: not reset. It is preloaded by the bench (backdoor); otherwise its contents are X.

## Timing
- A request sampled at edge t produces `rsp_valid`=1 in the cycle following edge t+`LATENCY`. The observed request-to-response distance is exactly `LATENCY` cycles.
- All outputs are registered. `rsp_valid` is a single-cycle pulse per request.
- When `rsp_valid`=0, `rsp_data`, `rsp_bus_error` and `rsp_thread_id` hold 0.
- Back-to-back requests on consecutive cycles produce responses on consecutive cycles.
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_bus_error`=0, `rsp_thread_id`=0, `overflow_error`=0. The queue is empty and the pointers are 0.
- Reset mid-operation:
  - All queued requests are discarded and produce no response, including any response due in the reset cycle.
  - A `req_valid` present while `reset`=1 is ignored.
  - A store that has not yet been serviced does not modify the array.

## Test plan
- Single read: set `LATENCY`=4, preload mem[0x10]=0xA5A5…, thread 1 reads at cycle 0. Required: `rsp_valid` in cycle 4 only, `rsp_data`=0xA5A5…, `rsp_thread_id`=1, `rsp_bus_error`=0.
- Two threads back-to-back: thread 0 reads line 0x2 at cycle 0, thread 1 reads line 0x3 at cycle 1. Required: responses in cycles 4 and 5, in order, with the correct data and thread ids; no overlap.
- Bus error: read addr=`NUM_LINES` (4096). Required: after `LATENCY`, `rsp_bus_error`=1, `rsp_data`=0, and the array is unchanged.
- Store then read: store 0x1234… to line 7 at cycle 0, read line 7 at cycle 1. Required: the first response echoes 0x1234…, and the second returns 0x1234….
- Overflow: set `QUEUE_DEPTH`=2 and issue 3 requests on consecutive cycles. Required: `overflow_error`=1 from cycle 3 onward, exactly 2 responses, and the third request never answered.
- Reset mid-flight: issue a read at cycle 0 and pulse reset at cycle 2. Required: no `rsp_valid` afterwards, and all outputs 0 after reset.

Source files
------------

// File: rtl/icache_fill_responder.sv
// Main-memory stand-in for I$ line fills: queues miss requests and answers each
// one with a full line (or an echoed store) after a fixed latency, in order.
package icache_fill_responder_pkg;
    localparam int unsigned THR_PER_CORE        = 4;
    localparam int unsigned THR_PER_CORE_WIDTH  = 2;
    localparam int unsigned ICACHE_LINE_WIDTH   = 128;
    localparam int unsigned ICACHE_RSH_VAL      = 4;
    localparam int unsigned MEM_ADDR_WIDTH      = 32;
    localparam int unsigned LINE_ADDR_WIDTH     = MEM_ADDR_WIDTH - ICACHE_RSH_VAL;
    localparam int unsigned MAIN_MEMORY_LATENCY = 10;

    typedef struct packed {
        logic [LINE_ADDR_WIDTH-1:0]    addr;
        logic                          is_store;
        logic [ICACHE_LINE_WIDTH-1:0]  data;
        logic [THR_PER_CORE_WIDTH-1:0] thread_id;
    } memory_request_t;
endpackage

module icache_fill_responder
    import icache_fill_responder_pkg::*;
#(
    parameter int unsigned LATENCY     = MAIN_MEMORY_LATENCY,
    parameter int unsigned NUM_LINES   = 4096,
    parameter int unsigned LINE_WIDTH  = ICACHE_LINE_WIDTH,
    parameter int unsigned QUEUE_DEPTH = THR_PER_CORE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    input  memory_request_t               req_info,
    output logic                          rsp_valid,
    output logic [LINE_WIDTH-1:0]         rsp_data,
    output logic                          rsp_bus_error,
    output logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id,
    output logic                          overflow_error
);
    localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned CD_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int unsigned ADDR_W = LINE_ADDR_WIDTH;

    // Backing store; intentionally not reset, preloaded from outside.
    logic [LINE_WIDTH-1:0] mem_q [NUM_LINES];

    memory_request_t          q_req_q [QUEUE_DEPTH];
    memory_request_t          q_req_d [QUEUE_DEPTH];
    logic [CD_W-1:0]          q_cd_q  [QUEUE_DEPTH];
    logic [CD_W-1:0]          q_cd_d  [QUEUE_DEPTH];
    logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [LINE_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [THR_PER_CORE_WIDTH-1:0] rsp_tid_q, rsp_tid_d;

    logic                     full_c, push_c, pop_c, mem_we_c;
    logic [IDX_W-1:0]         mem_idx_c;
    logic [LINE_WIDTH-1:0]    mem_wdata_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        q_req_d     = q_req_q;
        q_cd_d      = q_cd_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        rsp_tid_d   = '0;
        mem_we_c    = 1'b0;
        mem_idx_c   = '0;
        mem_wdata_c = '0;

        // Fullness is judged before this cycle's pop.
        full_c = (count_q == CNT_W'(QUEUE_DEPTH));
        pop_c  = (count_q != '0) && (q_cd_q[head_q] == '0);
        push_c = req_valid && !full_c;

        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (((i + QUEUE_DEPTH - int'(head_q)) % QUEUE_DEPTH) < int'(count_q)
                && (q_cd_q[i] != '0)) begin
                q_cd_d[i] = q_cd_q[i] - CD_W'(1);
            end
        end

        if (pop_c) begin
            head_d      = ptr_inc(head_q);
            rsp_valid_d = 1'b1;
            rsp_tid_d   = q_req_q[head_q].thread_id;
            if (q_req_q[head_q].addr < ADDR_W'(NUM_LINES)) begin
                mem_idx_c = IDX_W'(q_req_q[head_q].addr);
                if (q_req_q[head_q].is_store) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = LINE_WIDTH'(q_req_q[head_q].data);
                    rsp_data_d  = LINE_WIDTH'(q_req_q[head_q].data);
                end else begin
                    rsp_data_d  = mem_q[mem_idx_c];
                end
            end else begin
                rsp_err_d = 1'b1;
            end
        end

        if (push_c) begin
            q_req_d[tail_q] = req_info;
            q_cd_d[tail_q]  = CD_W'(LATENCY - 1);
            tail_d          = ptr_inc(tail_q);
        end

        if (req_valid && full_c) begin
            overflow_d = 1'b1;
        end

        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_req_q     <= '{default: '0};
            q_cd_q      <= '{default: '0};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tid_q   <= '0;
        end else begin
            q_req_q     <= q_req_d;
            q_cd_q      <= q_cd_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tid_q   <= rsp_tid_d;
        end
    end

    // A store popped in a reset cycle is discarded along with the queue.
    always_ff @(posedge clock) begin
        if (mem_we_c && !reset) begin
            mem_q[mem_idx_c] <= mem_wdata_c;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_bus_error  = rsp_err_q;
    assign rsp_thread_id  = rsp_tid_q;
    assign overflow_error = overflow_q;
endmodule
